// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO and start/busy handshake sequencer feeding a UART
// transmitter. Host bytes are queued on clk. Each byte is presented on
// tx_data with tx_start held until the synchronised tx_busy acknowledges it.
// The block then waits for the frame to finish before launching the next byte.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   wr_en       host write strobe, one byte per cycle
//   wr_data     host byte
//   flush       synchronous FIFO clear (in-flight byte unaffected)
//   tx_busy     transmitter busy, baud domain (double-flopped here)
//   tx_start    transmit request
//   tx_data     byte under transmission
//   full/empty  occupancy flags decoded from count
//   count       current occupancy, 0..DEPTH
//   overflow    one-cycle pulse when a write is dropped on a full FIFO
//   timeout_err one-cycle pulse when a start is not acknowledged in time
module uart_tx_fifo #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned START_TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     timeout_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(START_TIMEOUT) + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_busy_m;
  logic            r_busy_s;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_timer;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic            r_overflow;
  logic            r_timeout_err;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // A launch pops the head; a same-cycle pop frees the slot for a write.
  assign w_pop  = (r_state == S_IDLE) && !w_empty && !r_busy_s;
  assign w_push = wr_en && !flush && (!w_full || w_pop);
  assign w_drop = wr_en && !flush && w_full && !w_pop;

  // Two-flop synchroniser for the baud-domain busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy_m <= 1'b0;
      r_busy_s <= 1'b0;
    end else begin
      r_busy_m <= tx_busy;
      r_busy_s <= r_busy_m;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and overflow flag; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Handshake sequencer: one outstanding request at a time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_data  <= r_mem[r_rd_ptr];
            r_tx_start <= 1'b1;
            r_timer    <= '0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (r_busy_s) begin
            r_tx_start <= 1'b0;
            r_state    <= S_WAIT;
          end else if (r_timer == TIMER_LAST) begin
            // Unacknowledged request: drop the byte and move on.
            r_tx_start    <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_WAIT: begin
          if (!r_busy_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a behavioural transmitter answers
// tx_start with tx_busy, and every launched byte is checked in order against
// a queue of bytes the bench expects to be transmitted.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       timeout_err;

  uart_tx_fifo #(.DEPTH(16), .START_TIMEOUT(4096)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .flush       (flush),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Transmitter model controls
  logic force_busy = 1'b0;
  logic xm_busy    = 1'b0;
  logic xm_active  = 1'b0;
  logic xm_en      = 1'b0;
  int   xm_ack_dly = 3;
  int   xm_busy_len = 20;

  assign tx_busy = xm_busy | force_busy;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_launch = 0;
  int n_ovf = 0;
  int t_rise = 0;
  int st_len = 0;
  int last_len = 0;
  logic st_prev = 1'b0;
  logic [7:0] cap = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Launch monitor: scoreboard pop on every tx_start rise.
  initial begin : mon
    forever begin
      @(negedge clk);
      if (rst && tx_start && !st_prev) begin
        n_launch++;
        cap = tx_data;
        t_rise = cyc;
        st_len = 0;
        chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("tx_order", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (tx_start) st_len++;
      if (rst && !tx_start && st_prev) begin
        chk("tx_data_hold", 32'(tx_data), 32'(cap));
        last_len = st_len;
      end
      if (overflow) n_ovf++;
      st_prev = tx_start;
    end
  end

  // Behavioural transmitter: acks after xm_ack_dly, busy for xm_busy_len.
  initial begin : xmit
    forever begin
      @(negedge clk);
      if (xm_en && rst && tx_start && !xm_active) begin
        xm_active = 1'b1;
        repeat (xm_ack_dly) @(negedge clk);
        xm_busy = 1'b1;
        repeat (xm_busy_len) @(negedge clk);
        xm_busy = 1'b0;
        xm_active = 1'b0;
      end
    end
  end

  task automatic wr(input logic [7:0] d, input bit acc);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = d;
    if (acc) exp_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || xm_active || tx_start || xm_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 1);
    repeat (6) @(negedge clk);
  endtask

  initial begin : main
    int n;
    int base;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_txstart", 32'(tx_start), 0);
    chk("rst_txdata", 32'(tx_data), 0);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_no_launch", 32'(n_launch), 0);
    chk("idle_empty", 32'(empty), 1);

    // Single byte with a long frame
    xm_en = 1'b1;
    xm_ack_dly = 10;
    xm_busy_len = 2000;
    base = n_launch;
    wr(8'hA5, 1'b1);
    wait_idle(3000, "single_done");
    chk("single_start_len", 32'(last_len), 13);
    chk("single_launches", 32'(n_launch - base), 1);
    chk("single_empty", 32'(empty), 1);
    chk("single_txdata", 32'(tx_data), 32'h A5);

    // Burst fill with transmitter busy: 17th write overflows
    xm_ack_dly = 3;
    xm_busy_len = 20;
    @(negedge clk);
    force_busy = 1'b1;
    repeat (3) @(negedge clk);
    base = n_launch;
    n_ovf = 0;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      if (i < 16) exp_q.push_back(8'(i));
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("burst_count", 32'(count), 16);
    chk("burst_full", 32'(full), 1);
    chk("burst_ovf_pulse", 32'(overflow), 1);
    @(negedge clk);
    chk("burst_ovf_clear", 32'(overflow), 0);
    chk("burst_ovf_count", 32'(n_ovf), 1);
    chk("burst_no_launch", 32'(n_launch - base), 0);

    // Release busy; write in the exact cycle the first pop happens
    force_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h11;
    exp_q.push_back(8'h11);
    @(negedge clk);
    wr_en = 1'b0;
    chk("pushpop_count", 32'(count), 16);
    chk("pushpop_ovf", 32'(overflow), 0);
    chk("pushpop_launch", 32'(tx_start), 1);
    wait_idle(5000, "burst_drain");
    chk("burst_launches", 32'(n_launch - base), 17);
    chk("burst_empty", 32'(empty), 1);
    chk("burst_ovf_total", 32'(n_ovf), 1);

    // Start timeout: transmitter ignores the request
    xm_en = 1'b0;
    wr(8'h3C, 1'b1);
    wr(8'h5A, 1'b1);
    n = 0;
    while (!timeout_err && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_seen", 32'(timeout_err), 1);
    chk("timeout_latency", 32'(cyc - t_rise), 4096);
    chk("timeout_txstart", 32'(tx_start), 0);
    xm_en = 1'b1;
    @(negedge clk);
    chk("timeout_pulse_width", 32'(timeout_err), 0);
    wait_idle(500, "timeout_next_done");
    chk("timeout_empty", 32'(empty), 1);

    // Flush while the first byte is in WAIT_DONE
    xm_busy_len = 50;
    base = n_launch;
    exp_q.push_back(8'hB0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 8'hB0 + 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (!tx_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("flush_pre_count", 32'(count), 4);
    chk("flush_pre_txstart", 32'(tx_start), 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_txdata", 32'(tx_data), 32'h B0);
    wait_idle(500, "flush_done");
    repeat (100) @(negedge clk);
    chk("flush_launches", 32'(n_launch - base), 1);

    // Asynchronous reset in the middle of START
    xm_en = 1'b0;
    wr(8'h77, 1'b1);
    n = 0;
    while (!tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_start_seen", 32'(tx_start), 1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_txstart", 32'(tx_start), 0);
    chk("rstmid_txdata", 32'(tx_data), 0);
    chk("rstmid_count", 32'(count), 0);
    chk("rstmid_empty", 32'(empty), 1);
    chk("rstmid_full", 32'(full), 0);
    chk("rstmid_ovf", 32'(overflow), 0);
    chk("rstmid_tmo", 32'(timeout_err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("final_txstart", 32'(tx_start), 0);
    chk("final_sb_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
